// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field bit positions, loader FSM states.
// Pure declarations, no timing.
// Not applicable (no handshakes in a package).
package cpu_pkg;

    // Opcode map shared by the loader and the ControllerUnit.
    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_SLT = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd6;
    localparam logic [5:0] OP_SW  = 6'd7;
    localparam logic [5:0] OP_JMP = 6'd8;
    localparam logic [5:0] OP_BEQ = 6'd9;
    localparam logic [5:0] OP_BNE = 6'd10;

    // Field bit positions inside the 32-bit instruction word.
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int JADDR_MSB = 25;
    localparam int JADDR_LSB = 0;

    localparam int INSTR_W = 32;

    // Loader session FSM.
    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_ACCEPT = 2'd1,
        LD_WRITE  = 2'd2,
        LD_DONE   = 2'd3
    } ld_state_t;

    // Opcodes above BNE have no encoding.
    function automatic logic op_is_legal(input logic [5:0] op);
        return (op <= OP_BNE);
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into a 32-bit word and flags unknown opcodes.
// Purely combinational, zero cycles.
// No flow control; the caller samples word/illegal when it needs them.
// Ports: opcode/rs/rt/rd/imm/jaddr field inputs; word = encoded instruction; illegal = opcode > BNE.
module instr_encoder
    import cpu_pkg::*;
(
    input  logic [5:0]         opcode,
    input  logic [4:0]         rs,
    input  logic [4:0]         rt,
    input  logic [4:0]         rd,
    input  logic [15:0]        imm,
    input  logic [25:0]        jaddr,
    output logic [INSTR_W-1:0] word,
    output logic               illegal
);

    always_comb begin
        word    = '0;
        illegal = !op_is_legal(opcode);
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                // R-type: shamt/funct bits stay zero.
                word[OP_MSB:OP_LSB] = opcode;
                word[RS_MSB:RS_LSB] = rs;
                word[RT_MSB:RT_LSB] = rt;
                word[RD_MSB:RD_LSB] = rd;
            end
            OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
                word[OP_MSB:OP_LSB]   = opcode;
                word[RS_MSB:RS_LSB]   = rs;
                word[RT_MSB:RT_LSB]   = rt;
                word[IMM_MSB:IMM_LSB] = imm;
            end
            OP_JMP: begin
                word[OP_MSB:OP_LSB]       = opcode;
                word[JADDR_MSB:JADDR_LSB] = jaddr;
            end
            default: begin
                // NOP and illegal opcodes both produce an all-zero word.
                word = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Accepts instruction fields over a valid/ready handshake, encodes them, and writes one word per session slot into imem.
// Latency: handshake in cycle N -> imem_we in cycle N+1; one word every 2 cycles at best.
// Backpressure: in_ready is high only in ACCEPT; it drops during the write cycle and after the session completes.
// Ports: clk/rst_n; start opens a session; in_valid/in_ready + fields + in_last form the input stream;
//        imem_we/imem_addr/imem_wdata drive instruction memory; busy/done/err_illegal/overflow/count report status.
module instr_loader
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8    // DEPTH must equal 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       jaddr,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              overflow,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ld_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [31:0]        word_q,  word_d;
    logic               last_q,  last_d;
    logic               err_q,   err_d;
    logic               ovf_q,   ovf_d;

    logic [31:0]        enc_word;
    logic               enc_illegal;

    instr_encoder u_encoder (
        .opcode  (opcode),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .imm     (imm),
        .jaddr   (jaddr),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Handshake and write strobes are decoded from the state register so that
    // an asynchronous reset removes them in the same instant.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        word_d   = word_q;
        last_d   = last_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        in_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            LD_IDLE: begin
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = LD_ACCEPT;
                end
            end
            LD_ACCEPT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                // start is deliberately ignored here: a session cannot be restarted mid-flight.
                if (in_valid) begin
                    word_d  = enc_word;
                    last_d  = in_last;
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end
                    state_d = LD_WRITE;
                end
            end
            LD_WRITE: begin
                imem_we = 1'b1;
                busy    = 1'b1;
                count_d = count_q + (ADDR_W+1)'(1);
                if (last_q) begin
                    state_d = LD_DONE;
                end else if (addr_q == LAST_ADDR) begin
                    // Memory full with more instructions pending: stop and flag it.
                    ovf_d   = 1'b1;
                    state_d = LD_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = LD_ACCEPT;
                end
            end
            LD_DONE: begin
                done = 1'b1;
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = LD_ACCEPT;
                end
            end
            default: begin
                state_d = LD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LD_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            word_q  <= word_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign imem_addr   = addr_q;
    assign imem_wdata  = word_q;
    assign err_illegal = err_q;
    assign overflow    = ovf_q;
    assign count       = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader, built with a 4-word memory so overflow is reachable.
// Each scenario task drives its own stimulus and checks inline.
// A monitor logs every imem write into a shadow memory for the tasks to inspect.
module tb_instr_loader;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       jaddr;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              overflow;
    logic [ADDR_W:0]   count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [DEPTH];
    int          wr_cnt = 0;

    instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm         (imm),
        .jaddr       (jaddr),
        .in_last     (in_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .busy        (busy),
        .done        (done),
        .err_illegal (err_illegal),
        .overflow    (overflow),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            mem[imem_addr] = imem_wdata;
            wr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one instruction and returns one step after the accepting edge (the write cycle).
    task automatic send(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [15:0] im, input logic [25:0] ja,
                        input logic last);
        bit ok = 0;
        opcode = op; rs = s; rt = t; rd = d; imm = im; jaddr = ja; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                tick();
                ok = 1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready never high for opcode %0d", op);
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL done_timeout done got %b want 1", done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (imem_we !== 1'b0)      begin errors++; $display("FAIL rst_imem_we got %b want 0", imem_we); end
        checks++; if (imem_addr !== 2'd0)    begin errors++; $display("FAIL rst_imem_addr got %h want 0", imem_addr); end
        checks++; if (imem_wdata !== 32'd0)  begin errors++; $display("FAIL rst_imem_wdata got %h want 0", imem_wdata); end
        checks++; if ({busy, done, err_illegal, overflow} !== 4'b0000)
            begin errors++; $display("FAIL rst_status got %b want 0000", {busy, done, err_illegal, overflow}); end
        checks++; if (count !== 3'd0)        begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        pulse_start();
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1)
            begin errors++; $display("FAIL add_accept busy/in_ready got %b%b want 11", busy, in_ready); end
        send(6'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        // Write must appear in the cycle right after the handshake.
        checks++; if (imem_we !== 1'b1)      begin errors++; $display("FAIL add_latency imem_we got %b want 1", imem_we); end
        checks++; if (imem_addr !== 2'd0)    begin errors++; $display("FAIL add_addr got %0d want 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h04221800) begin errors++; $display("FAIL add_wdata got %h want 04221800", imem_wdata); end
        checks++; if (in_ready !== 1'b0)     begin errors++; $display("FAIL add_write_ready got %b want 0", in_ready); end
        wait_done();
        checks++; if (count !== 3'd1)        begin errors++; $display("FAIL add_count got %0d want 1", count); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL add_busy_done got %b want 0", busy); end
    endtask

    task automatic test_lw_beq();
        int base = wr_cnt;
        pulse_start();
        checks++; if (count !== 3'd0 || done !== 1'b0)
            begin errors++; $display("FAIL lw_restart count/done got %0d/%b want 0/0", count, done); end
        send(6'd6, 5'd4, 5'd5, 5'd0, 16'h0010, 26'h0, 1'b0);
        send(6'd9, 5'd1, 5'd1, 5'd0, 16'hFFFF, 26'h0, 1'b1);
        wait_done();
        checks++; if (mem[0] !== 32'h18850010) begin errors++; $display("FAIL lw_word got %h want 18850010", mem[0]); end
        checks++; if (mem[1] !== 32'h2421FFFF) begin errors++; $display("FAIL beq_word got %h want 2421ffff", mem[1]); end
        checks++; if (count !== 3'd2)          begin errors++; $display("FAIL lw_beq_count got %0d want 2", count); end
        checks++; if (wr_cnt - base !== 2)     begin errors++; $display("FAIL lw_beq_writes got %0d want 2", wr_cnt - base); end
    endtask

    task automatic test_illegal();
        pulse_start();
        send(6'd63, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL illegal_sticky_early got %b want 1", err_illegal); end
        send(6'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000040, 1'b1);
        wait_done();
        checks++; if (mem[0] !== 32'h0)        begin errors++; $display("FAIL illegal_word got %h want 0", mem[0]); end
        checks++; if (mem[1] !== 32'h20000040) begin errors++; $display("FAIL jmp_word got %h want 20000040", mem[1]); end
        checks++; if (err_illegal !== 1'b1)    begin errors++; $display("FAIL illegal_flag got %b want 1", err_illegal); end
        checks++; if (count !== 3'd2)          begin errors++; $display("FAIL illegal_count got %0d want 2", count); end
    endtask

    task automatic test_overflow();
        int base = wr_cnt;
        pulse_start();
        checks++; if (err_illegal !== 1'b0) begin errors++; $display("FAIL ovf_err_cleared got %b want 0", err_illegal); end
        for (int i = 0; i < 4; i++) begin
            send(6'd6, 5'd0, 5'd0, 5'd0, 16'(i + 1), 26'h0, 1'b0);
        end
        wait_done();
        checks++; if (overflow !== 1'b1)       begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (count !== 3'd4)          begin errors++; $display("FAIL ovf_count got %0d want 4", count); end
        checks++; if (wr_cnt - base !== 4)     begin errors++; $display("FAIL ovf_writes got %0d want 4", wr_cnt - base); end
        checks++; if (mem[0] !== 32'h18000001 || mem[3] !== 32'h18000004)
            begin errors++; $display("FAIL ovf_words got %h/%h want 18000001/18000004", mem[0], mem[3]); end
        // Fifth instruction must never be taken.
        opcode = 6'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_fifth_ready got %b want 0", in_ready); end
        end
        in_valid = 1'b0;
        checks++; if (wr_cnt - base !== 4 || done !== 1'b1)
            begin errors++; $display("FAIL ovf_fifth_write writes %0d done %b want 4 1", wr_cnt - base, done); end
    endtask

    task automatic test_reset_in_write();
        int base = wr_cnt;
        pulse_start();
        send(6'd2, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0);
        send(6'd3, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 1'b0);
        checks++; if (imem_we !== 1'b1 || imem_addr !== 2'd1)
            begin errors++; $display("FAIL rw_pre we/addr got %b/%0d want 1/1", imem_we, imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_we !== 1'b0)      begin errors++; $display("FAIL rw_we_drop got %b want 0", imem_we); end
        checks++; if ({busy, done, err_illegal, overflow} !== 4'b0000 || count !== 3'd0 || imem_addr !== 2'd0)
            begin errors++; $display("FAIL rw_status got %b cnt %0d addr %0d want 0000 0 0",
                                     {busy, done, err_illegal, overflow}, count, imem_addr); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (wr_cnt - base !== 1)   begin errors++; $display("FAIL rw_partial writes got %0d want 1", wr_cnt - base); end
        pulse_start();
        send(6'd4, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1);
        checks++; if (imem_addr !== 2'd0 || imem_wdata !== 32'h10E84800)
            begin errors++; $display("FAIL rw_restart addr %0d data %h want 0 10e84800", imem_addr, imem_wdata); end
        wait_done();
        checks++; if (count !== 3'd1)        begin errors++; $display("FAIL rw_restart_count got %0d want 1", count); end
    endtask

    task automatic test_ignored_inputs();
        int base;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        base = wr_cnt;
        opcode = 6'd1; in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || wr_cnt !== base)
            begin errors++; $display("FAIL idle_valid busy %b ready %b writes %0d want 0 0 0", busy, in_ready, wr_cnt - base); end
        pulse_start();
        send(6'd5, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        pulse_start();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b1 || count !== 3'd1 || imem_addr !== 2'd1)
            begin errors++; $display("FAIL accept_start ready %b busy %b cnt %0d addr %0d want 1 1 1 1",
                                     in_ready, busy, count, imem_addr); end
        send(6'd7, 5'd3, 5'd4, 5'd0, 16'h1234, 26'h0, 1'b1);
        wait_done();
        checks++; if (mem[1] !== 32'h1C641234 || count !== 3'd2 || wr_cnt - base !== 2)
            begin errors++; $display("FAIL accept_start_after word %h cnt %0d writes %0d want 1c641234 2 2",
                                     mem[1], count, wr_cnt - base); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        opcode = '0; rs = '0; rt = '0; rd = '0; imm = '0; jaddr = '0;
        test_reset();
        test_single_add();
        test_lw_beq();
        test_illegal();
        test_overflow();
        test_reset_in_write();
        test_ignored_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
